// File: rtl/parity_checker.sv
// Serial receive-side checker for the 3-bit odd-parity code (a0, a1, a2, F).
// Recovers each word, flags parity mismatches and keeps a saturating error count.
module parity_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_sof,
   output logic             out_valid,
   output logic [2:0]       out_data,
   output logic             parity_err,
   output logic             sync_err,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_D0, S_D1, S_D2, S_P} state_t;

   state_t     state;
   logic [2:0] bits;
   logic       frame_ok;

   // Odd parity over the three captured bits plus the incoming F bit.
   assign frame_ok = bits[0] ^ bits[1] ^ bits[2] ^ in_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_D0;
         bits       <= 3'b000;
         out_valid  <= 1'b0;
         out_data   <= 3'b000;
         parity_err <= 1'b0;
         sync_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         if (in_valid) begin
            // A start-of-frame always restarts capture, aborting any partial frame.
            if (in_sof) begin
               bits  <= {2'b00, in_bit};
               state <= S_D1;
               if (state != S_D0) begin
                  sync_err <= 1'b1;
               end
            end else begin
               case (state)
                  S_D0: begin
                     bits  <= {2'b00, in_bit};
                     state <= S_D1;
                  end
                  S_D1: begin
                     bits[1] <= in_bit;
                     state   <= S_D2;
                  end
                  S_D2: begin
                     bits[2] <= in_bit;
                     state   <= S_P;
                  end
                  S_P: begin
                     out_data   <= bits;
                     parity_err <= ~frame_ok;
                     out_valid  <= 1'b1;
                     state      <= S_D0;
                     if (!frame_ok && (err_count != {CNT_W{1'b1}})) begin
                        err_count <= err_count + CNT_W'(1);
                     end
                  end
                  default: state <= S_D0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: directed test-plan sequences plus
// randomized traffic, compared against a frame-level queue model every cycle.
module tb_parity_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_bit;
   logic       in_sof;

   logic       out_valid, parity_err, sync_err;
   logic [2:0] out_data;
   logic [7:0] err_count;

   logic       sat_valid, sat_perr, sat_sync;
   logic [2:0] sat_data;
   logic [1:0] sat_count;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int   q[$];
   logic exp_valid, exp_sync, exp_perr;
   logic [2:0] exp_data;
   int   exp_cnt8, exp_cnt2;

   parity_checker dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
      .out_valid(out_valid), .out_data(out_data), .parity_err(parity_err),
      .sync_err(sync_err), .err_count(err_count)
   );

   parity_checker #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
      .out_valid(sat_valid), .out_data(sat_data), .parity_err(sat_perr),
      .sync_err(sat_sync), .err_count(sat_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Frame-level model: collect valid bits in a queue, judge the frame at four bits.
   task automatic modelStep(input logic rst, input logic v, input logic s, input logic b);
      int sum;
      exp_valid = 1'b0;
      exp_sync  = 1'b0;
      if (rst) begin
         q.delete();
         exp_data = 3'b000;
         exp_perr = 1'b0;
         exp_cnt8 = 0;
         exp_cnt2 = 0;
      end else if (v) begin
         if (s) begin
            if (q.size() != 0) exp_sync = 1'b1;
            q.delete();
         end
         q.push_back(int'(b));
         if (q.size() == 4) begin
            sum = q[0] + q[1] + q[2] + q[3];
            exp_data  = {q[2][0], q[1][0], q[0][0]};
            exp_perr  = (sum % 2) == 0;
            exp_valid = 1'b1;
            if (exp_perr) begin
               if (exp_cnt8 < 255) exp_cnt8++;
               if (exp_cnt2 < 3) exp_cnt2++;
            end
            q.delete();
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("sync_err", 32'(sync_err), 32'(exp_sync));
      checkOutput("out_data", 32'(out_data), 32'(exp_data));
      checkOutput("parity_err", 32'(parity_err), 32'(exp_perr));
      checkOutput("err_count", 32'(err_count), 32'(exp_cnt8));
      checkOutput("sat_valid", 32'(sat_valid), 32'(exp_valid));
      checkOutput("sat_sync", 32'(sat_sync), 32'(exp_sync));
      checkOutput("sat_count", 32'(sat_count), 32'(exp_cnt2));
   endtask

   // Drive one cycle, advance the model on the same edge, then compare.
   task automatic applyStimulus(input logic v, input logic s, input logic b);
      in_valid = v;
      in_sof   = s;
      in_bit   = b;
      @(posedge clk);
      modelStep(reset, v, s, b);
      #1;
      checkAll();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
   endtask

   task automatic sendFrame(input logic a0, input logic a1, input logic a2, input logic f, input int gap);
      logic [3:0] fr;
      fr = {f, a2, a1, a0};
      for (int i = 0; i < 4; i++) begin
         idleCycles(gap);
         applyStimulus(1'b1, 1'b0, fr[i]);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      reset = 1'b0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      in_bit = 1'b0;
      exp_data = 3'b000;
      exp_perr = 1'b0;
      exp_cnt8 = 0;
      exp_cnt2 = 0;

      doReset();
      checkOutput("reset_data", 32'(out_data), 32'h0);
      checkOutput("reset_count", 32'(err_count), 32'h0);

      // Good frames back-to-back, then a bad frame and a good one
      sendFrame(0, 0, 0, 1, 0);
      checkOutput("plan_data0", 32'(out_data), 32'h0);
      sendFrame(1, 0, 1, 1, 0);
      checkOutput("plan_data1", 32'(out_data), 32'h5);
      sendFrame(1, 1, 1, 0, 0);
      checkOutput("plan_data2", 32'(out_data), 32'h7);
      checkOutput("plan_cnt_good", 32'(err_count), 32'h0);
      sendFrame(1, 1, 0, 0, 0);
      checkOutput("plan_bad_data", 32'(out_data), 32'h3);
      checkOutput("plan_bad_perr", 32'(parity_err), 32'h1);
      checkOutput("plan_bad_cnt", 32'(err_count), 32'h1);
      sendFrame(0, 1, 0, 0, 0);
      checkOutput("plan_good_data", 32'(out_data), 32'h2);
      checkOutput("plan_good_cnt", 32'(err_count), 32'h1);

      // Resync mid-frame
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 1);
      checkOutput("plan_sync", 32'(sync_err), 32'h1);
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 1);
      checkOutput("plan_resync_data", 32'(out_data), 32'h3);
      checkOutput("plan_resync_perr", 32'(parity_err), 32'h0);

      // Gapped frames
      for (int g = 0; g < 4; g++) sendFrame(1, 0, 1, 1, g);
      sendFrame(1, 1, 0, 0, 3);
      checkOutput("plan_gap_perr", 32'(parity_err), 32'h1);

      // Saturation on the 2-bit counter instance
      doReset();
      for (int i = 0; i < 5; i++) begin
         sendFrame(0, 0, 0, 0, i % 2);
         checkOutput("plan_sat_cnt", 32'(sat_count), 32'(sat_exp[i]));
         checkOutput("plan_sat_perr", 32'(sat_perr), 32'h1);
      end

      // Reset mid-frame
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 1);
      doReset();
      checkOutput("plan_rst_count", 32'(err_count), 32'h0);
      sendFrame(0, 0, 1, 0, 0);
      checkOutput("plan_rst_data", 32'(out_data), 32'h4);
      checkOutput("plan_rst_perr", 32'(parity_err), 32'h0);

      // Exhaustive frame compare
      doReset();
      for (int c = 0; c < 16; c++) begin
         logic [3:0] cv;
         cv = 4'(c);
         sendFrame(cv[0], cv[1], cv[2], cv[3], 0);
         checkOutput("plan_exh_perr", 32'(parity_err), 32'(~^cv));
      end
      checkOutput("plan_exh_cnt", 32'(err_count), 32'd8);

      // Random traffic with occasional sof, gaps and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset();
         end else begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                          1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_checker.md
# parity_checker

Serial receive-side checker for the 3-bit odd-parity code produced by the lab parity generator, where F = ~(a0 ^ a1 ^ a2). The block accepts frames one bit per valid cycle: data bits a0, a1, a2, then the parity bit F. For each frame it presents the recovered 3-bit word, flags a parity mismatch, and keeps a saturating error count. It sits between a serial link or shift source and the lab display/LED logic.

## Interface
- CNT_W, default 8: width of the error counter.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is sampled on this cycle.
- in_bit  input  1  serial data bit. Order within a frame is a0, a1, a2, F.
- in_sof  input  1  start of frame. Meaningful only when in_valid=1. It marks the current bit as a0.
- out_valid  output  1  one-cycle pulse when a complete frame has been checked.
- out_data  output  3  recovered word {a2,a1,a0}. Held between frames.
- parity_err  output  1  result for the last checked frame. 1 means a0^a1^a2^F == 0. Held between frames.
- sync_err  output  1  one-cycle pulse when in_sof arrives while a partial frame is in progress.
- err_count  output  CNT_W  number of parity errors. Saturates at all-ones.

## Operation
- FSM states: S_D0, S_D1, S_D2, S_P. Reset state is S_D0.
- The FSM advances only on cycles with in_valid=1. When in_valid=0, state and data hold.
- S_D0 → S_D1: capture a0. S_D1 → S_D2: capture a1. S_D2 → S_P: capture a2.
- S_P → S_D0: capture F, then evaluate ok = a0^a1^a2^F.
  - ok=1 means the frame is good. ok=0 means a parity error.
  - On the same clock edge:
    - load out_data with {a2,a1,a0};
    - load parity_err with ~ok;
    - set out_valid=1 for one cycle;
    - if ok=0 and err_count < 2^CNT_W-1, increment err_count.
- in_sof=1 with in_valid=1:
  - The bit is always taken as a0 and the state becomes S_D1.
  - If the state was not S_D0, the partial frame is discarded. sync_err pulses for one cycle. No out_valid is produced and err_count is unchanged.
  - If the state was S_D0, there is no sync_err.
- in_sof with in_valid=0 is ignored.
- in_sof=0 in S_D0 is legal. Frames may be sent back-to-back without in_sof.
- err_count saturation: at all-ones, further parity errors leave it at all-ones. There is no wrap-around.
- Reset (also mid-frame):
  - state = S_D0;
  - out_data = 3'b000, parity_err = 0, out_valid = 0, sync_err = 0;
  - err_count = 0;
  - captured bits are cleared.
  - Reset has priority over in_valid and in_sof in the same cycle.

## Timing
- All outputs are registered and update only on the rising edge of clk.
- Latency: out_valid, out_data and parity_err appear on the edge that samples F. They are visible during the cycle after the F cycle.
- err_count reflects the frame on that same edge.
- Minimum frame length is 4 valid cycles. Full throughput is one frame every 4 cycles, with out_valid pulsing every 4th cycle.
- Gaps (in_valid=0) anywhere inside a frame are allowed and do not alter the result.
- The cycle after reset deasserts may carry a valid a0.
- out_valid and sync_err are never high in the same cycle.
  - This holds because in_sof in S_P aborts the frame instead of completing it.

## Test plan
- Good frames, back-to-back. After reset, send a0,a1,a2,F = 0,0,0,1, then 1,0,1,1, then 1,1,1,0.
  - Expect three out_valid pulses, 4 cycles apart.
  - out_data = 000, 101, 111 respectively.
  - parity_err = 0 each time; err_count = 0.
- Bad frame. Send 1,1,0,0.
  - out_valid pulse; out_data = 011; parity_err = 1; err_count = 1.
  - A following good frame 0,1,0,0 gives out_data = 010, parity_err = 0, err_count stays 1.
- Gaps and resync.
  - Send a0=1, a1=0, then in_sof=1 with bit 1.
    - Expect a sync_err pulse and no out_valid.
  - Continue with 1,0,1.
    - Expect out_valid, out_data = 011, parity_err = 0 (1^1^0^1 = 1).
  - Insert in_valid=0 gaps of 0, 1 and 3 cycles between bits.
    - Results are identical to the gap-free run.
- Saturation, with CNT_W=2. Send 5 bad frames (0,0,0,0).
  - err_count goes 1, 2, 3, 3, 3; parity_err = 1 each time.
- Reset mid-operation. Send a0,a1 = 1,1, then assert reset for 1 cycle.
  - All outputs are 0.
  - The next 4 bits 0,0,1,0 form a fresh frame: out_data = 100, parity_err = 0.
- Exhaustive compare. Drive all 16 combinations of {a0,a1,a2,F}.
  - parity_err = ~(a0^a1^a2^F) in every case.
  - err_count ends at 8.
